kt_cpu_mc: RTL
==============

Name: kt_cpu_mc

Overview:
- Parametrised, multicycle successor to the KT8 CPU core: same A/B/R register model, with an ALU result in R and an R==0 branch.
- Generalised data, RAM-address and program-address widths.
- Adds req/ack handshakes to program memory and RAM, so wait-stated memories are supported.
- Adds a bounded hardware call/return stack with fault detection and halt.
- Sits between program ROM and data RAM, like the 8-bit core, with program memory and RAM external.

Parameters:
- DATA_W, 8: width of A, B, R and the RAM data bus.
- RADDR_W, 5: RAM address width. Must satisfy RADDR_W <= INSN_W-3.
- PADDR_W, 8: program counter width. Must satisfy PADDR_W <= INSN_W-3.
- INSN_W, 11: instruction width. Operand field OPND_W = INSN_W-3.
- STACK_DEPTH, 4: number of return-stack entries, >= 1.

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: asynchronous reset, active-high.
- p_req_o, output, 1: instruction fetch request.
- p_addr_o, output, PADDR_W: fetch address, equal to PC.
- p_data_i, input, INSN_W: instruction word, valid when p_ack_i=1.
- p_ack_i, input, 1: fetch acknowledge.
- ram_req_o, output, 1: RAM access request.
- ram_we_o, output, 1: RAM write strobe, qualified by ram_req_o.
- ram_addr_o, output, RADDR_W: RAM address.
- ram_data_o, output, DATA_W: write data, always equal to R.
- ram_data_i, input, DATA_W: read data, valid when ram_ack_i=1.
- ram_ack_i, input, 1: RAM acknowledge.
- halted_o, output, 1: core stopped.
- fault_o, output, 1: stack overflow or underflow occurred; sticky until reset.

Behaviour:
- Reset (async): PC=0, A=B=R=0, SP=0, IR=0, state=BOOT, fault_o=0.
  - All request outputs are registered and reset to 0. ram_data_o=0, halted_o=0.
- Instruction fields:
  - cls = IR[INSN_W-1:INSN_W-3].
  - opnd = IR[OPND_W-1:0].
  - RAM address = opnd[RADDR_W-1:0].
- Instruction classes:
  - 000 LDA: A <= RAM[addr].
  - 001 LDB: B <= RAM[addr].
  - 010 ORB: B <= B | zero-extend/truncate(opnd) to DATA_W.
  - 011 ALU: R <= f(A,B,opnd[3:0]).
  - 100 STR: RAM[addr] <= R.
  - 101 JZ: if R==0, PC <= PC + sign-extended opnd; else PC+1.
  - 110 CALL: push PC+1, then PC <= opnd[PADDR_W-1:0].
  - 111 RET: PC <= pop.
- ALU ops, all results mod 2^DATA_W:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SHL A by 1, zero fill. 7 SHR A by 1, zero fill.
  - 8 PASS A, 9 PASS B.
  - 10-15 give 0.
- All PC arithmetic wraps mod 2^PADDR_W.
- States:
  - BOOT: one cycle, then FETCH.
  - FETCH: p_req_o=1, p_addr_o=PC. Hold until p_ack_i=1, then IR <= p_data_i and go to EXEC. p_ack_i is ignored in every other state.
  - EXEC:
    - ORB, ALU and JZ complete here, update PC, and go to FETCH.
    - CALL/RET complete here unless they fault.
    - LDA, LDB and STR go to MEM.
  - MEM: ram_req_o=1, ram_addr_o=addr, ram_we_o=1 only for STR. Hold until ram_ack_i=1.
    - On ack: LDA/LDB load from ram_data_i, PC <= PC+1, go to FETCH.
    - ram_ack_i is ignored outside MEM.
  - HALT: terminal until reset. All requests 0, halted_o=1.
- Timing with zero-wait acks: ORB, ALU, JZ, CALL and RET take 2 cycles; LDA, LDB and STR take 3 cycles. Each wait cycle on ack adds 1 cycle.
- Stack faults:
  - CALL with SP==STACK_DEPTH: overflow. Set fault_o=1 and go to HALT; PC and stack are unchanged.
  - RET with SP==0: underflow. Same handling.
  - Push and pop never occur in the same cycle.
- ram_data_o tracks R continuously.
- Asserting rst_i mid-request drops p_req_o/ram_req_o immediately. Any in-flight ack after reset is ignored while in BOOT.
- A JZ taken with offset 0 is a legal self-loop; it is not treated as a halt.

Test Plan:
- Reset, zero-wait acks, ROM = LDA 3; LDB 4; ALU ADD; STR 5, with RAM[3]=0x25, RAM[4]=0x1B.
  -> write of 0x40 to addr 5; STR request appears on cycle 11 after BOOT.
- Same program with ram_ack_i delayed 3 cycles on every access.
  -> identical result; ram_req_o and ram_addr_o held stable through each wait.
- R=0, JZ with opnd = -2 (INSN_W=11, i.e. 0xFE in 8-bit opnd) at PC=0x10.
  -> next p_addr_o=0x0E.
  - Repeat with R=1 -> next p_addr_o=0x11.
  - JZ +3 at PC=0xFE with R=0 -> next p_addr_o=0x01 (wrap).
- CALL 0x40 at PC=0x07, then RET at 0x40.
  -> fetch order 0x07, 0x40, 0x08. Four nested CALLs succeed; the fifth sets fault_o=1, halted_o=1, and no further p_req_o.
- RET right after reset -> underflow: fault_o=1 and HALT; PC stays 0x00.
- rst_i asserted during a MEM wait cycle of STR.
  -> ram_req_o and ram_we_o go to 0 asynchronously. After release: one BOOT cycle, then fetch from 0x00 with A=B=R=0.

Source files
------------

// File: rtl/kt_cpu_mc.sv
// kt_cpu_mc: multicycle A/B/R accumulator core with req/ack program and RAM ports
// and a bounded hardware return stack that halts on overflow/underflow.
module kt_cpu_mc #(
    parameter int DATA_W      = 8,
    parameter int RADDR_W     = 5,
    parameter int PADDR_W     = 8,
    parameter int INSN_W      = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               p_req_o,
    output logic [PADDR_W-1:0] p_addr_o,
    input  logic [INSN_W-1:0]  p_data_i,
    input  logic               p_ack_i,
    output logic               ram_req_o,
    output logic               ram_we_o,
    output logic [RADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0]  ram_data_o,
    input  logic [DATA_W-1:0]  ram_data_i,
    input  logic               ram_ack_i,
    output logic               halted_o,
    output logic               fault_o
);

    localparam int OPND_W = INSN_W - 3;
    localparam int SP_W   = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] C_LDA  = 3'd0;
    localparam logic [2:0] C_LDB  = 3'd1;
    localparam logic [2:0] C_ORB  = 3'd2;
    localparam logic [2:0] C_ALU  = 3'd3;
    localparam logic [2:0] C_STR  = 3'd4;
    localparam logic [2:0] C_JZ   = 3'd5;
    localparam logic [2:0] C_CALL = 3'd6;
    localparam logic [2:0] C_RET  = 3'd7;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t              state, state_n;
    logic [PADDR_W-1:0]  pc, pc_n, pc_inc, stack_top;
    logic [DATA_W-1:0]   a, a_n, b, b_n, r, r_n, alu_res, opnd_d;
    logic [INSN_W-1:0]   ir, ir_n;
    logic [SP_W-1:0]     sp, sp_n;
    logic                fault_n, push;
    logic [PADDR_W-1:0]  stack [STACK_DEPTH];

    logic [2:0]               cls;
    logic [OPND_W-1:0]        opnd;
    logic [DATA_W+OPND_W-1:0] opnd_wide;

    assign cls       = ir[INSN_W-1 -: 3];
    assign opnd      = ir[OPND_W-1:0];
    // Zero-extends or truncates the operand to DATA_W for either width relation.
    assign opnd_wide = {{DATA_W{1'b0}}, opnd};
    assign opnd_d    = opnd_wide[DATA_W-1:0];
    assign pc_inc    = pc + PADDR_W'(1);

    assign p_addr_o   = pc;
    assign ram_data_o = r;

    always_comb begin
        alu_res = '0;
        case (opnd[3:0])
            4'd0: alu_res = a + b;
            4'd1: alu_res = a - b;
            4'd2: alu_res = a & b;
            4'd3: alu_res = a | b;
            4'd4: alu_res = a ^ b;
            4'd5: alu_res = ~a;
            4'd6: alu_res = {a[DATA_W-2:0], 1'b0};
            4'd7: alu_res = {1'b0, a[DATA_W-1:1]};
            4'd8: alu_res = a;
            4'd9: alu_res = b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp == SP_W'(i + 1)) stack_top = stack[i];
        end
    end

    // Handshake: a request is held, with address stable, from the cycle it rises
    // until the cycle the matching ack is sampled high; acks seen in any other
    // state are ignored.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        a_n     = a;
        b_n     = b;
        r_n     = r;
        ir_n    = ir;
        sp_n    = sp;
        fault_n = fault_o;
        push    = 1'b0;
        case (state)
            S_BOOT: state_n = S_FETCH;
            S_FETCH: begin
                if (p_ack_i) begin
                    ir_n    = p_data_i;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                state_n = S_FETCH;
                case (cls)
                    C_LDA, C_LDB, C_STR: state_n = S_MEM;
                    C_ORB: begin
                        b_n  = b | opnd_d;
                        pc_n = pc_inc;
                    end
                    C_ALU: begin
                        r_n  = alu_res;
                        pc_n = pc_inc;
                    end
                    // Low PADDR_W operand bits equal the sign-extended offset mod 2^PADDR_W.
                    C_JZ: pc_n = (r == '0) ? pc + opnd[PADDR_W-1:0] : pc_inc;
                    C_CALL: begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            fault_n = 1'b1;
                            state_n = S_HALT;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + SP_W'(1);
                            pc_n = opnd[PADDR_W-1:0];
                        end
                    end
                    default: begin
                        if (sp == '0) begin
                            fault_n = 1'b1;
                            state_n = S_HALT;
                        end else begin
                            sp_n = sp - SP_W'(1);
                            pc_n = stack_top;
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (ram_ack_i) begin
                    if (cls == C_LDA) a_n = ram_data_i;
                    if (cls == C_LDB) b_n = ram_data_i;
                    pc_n    = pc_inc;
                    state_n = S_FETCH;
                end
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_BOOT;
            pc         <= '0;
            a          <= '0;
            b          <= '0;
            r          <= '0;
            ir         <= '0;
            sp         <= '0;
            p_req_o    <= 1'b0;
            ram_req_o  <= 1'b0;
            ram_we_o   <= 1'b0;
            ram_addr_o <= '0;
            halted_o   <= 1'b0;
            fault_o    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            a         <= a_n;
            b         <= b_n;
            r         <= r_n;
            ir        <= ir_n;
            sp        <= sp_n;
            p_req_o   <= (state_n == S_FETCH);
            ram_req_o <= (state_n == S_MEM);
            ram_we_o  <= (state_n == S_MEM) && (cls == C_STR);
            if (state_n == S_MEM) ram_addr_o <= opnd[RADDR_W-1:0];
            halted_o  <= (state_n == S_HALT);
            fault_o   <= fault_n;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push && sp == SP_W'(i)) stack[i] <= pc_inc;
            end
        end
    end

endmodule
